// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, data-memory wait and timeout trap.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined; otherwise they read as zero.
module pipeline_stall_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              id_ex_memread_i,
    input  logic [ADDR_W-1:0] id_ex_rd_i,
    input  logic [ADDR_W-1:0] if_id_rs1_i,
    input  logic [ADDR_W-1:0] if_id_rs2_i,
    input  logic              branch_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ack_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              pipe_freeze_o,
    output logic              mem_err_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic               mem_err_r, mem_err_s;
    logic               lu_s, mw_s, active_s;

    assign lu_s = id_ex_memread_i && (id_ex_rd_i != {ADDR_W{1'b0}}) &&
                  ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));
    assign mw_s     = dmem_req_i && !dmem_ack_i;
    assign active_s = (state_r == ST_RUN) || (state_r == ST_MEM_WAIT);
    assign mem_err_o = mem_err_r;

    // State, wait counter and sticky trap flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= ZERO_C;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            mem_err_r  <= mem_err_s;
        end
    end

    // Next-state logic; wait_cnt holds the number of consecutive wait cycles already elapsed
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        mem_err_s  = mem_err_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mw_s && (TIMEOUT_C == ONE_C)) begin
                    state_s   = ST_HALT;
                    mem_err_s = 1'b1;
                end else if (mw_s) begin
                    state_s    = ST_MEM_WAIT;
                    wait_cnt_s = ONE_C;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack_i || !dmem_req_i) begin
                    state_s    = ST_RUN;
                    wait_cnt_s = ZERO_C;
                end else if ((wait_cnt_r + ONE_C) == TIMEOUT_C) begin
                    state_s    = ST_HALT;
                    wait_cnt_s = wait_cnt_r + ONE_C;
                    mem_err_s  = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + ONE_C;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s    = ST_IDLE;
                wait_cnt_s = ZERO_C;
            end
        endcase
    end

    // Prioritised control outputs: memory wait, then load-use, then branch flush
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
        pipe_freeze_o  = 1'b1;
        if (active_s) begin
            if (mw_s) begin
                id_ex_bubble_o = 1'b0;
            end else if (lu_s) begin
                pipe_freeze_o  = 1'b0;
            end else if (branch_taken_i) begin
                pc_write_o     = 1'b1;
                if_id_write_o  = 1'b1;
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b0;
                pipe_freeze_o  = 1'b0;
            end else begin
                pc_write_o     = 1'b1;
                if_id_write_o  = 1'b1;
                id_ex_bubble_o = 1'b0;
                pipe_freeze_o  = 1'b0;
            end
        end else begin
            pc_write_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_r, flush_cnt_r;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (active_s && !pc_write_o) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (if_id_flush_o) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with a cycle-level behavioural model and literal pins.
module tb_pipeline_stall_ctrl;

    localparam int TP = 4;

    logic        clk, rst;
    logic        start, memread, br, req, ack;
    logic [4:0]  rd, rs1, rs2;
    logic        pc_write, if_id_write, if_id_flush, bubble, freeze, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_stall_ctrl #(.ADDR_W(5), .TIMEOUT(TP), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .id_ex_memread_i(memread), .id_ex_rd_i(rd),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2),
        .branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write),
        .if_id_flush_o(if_id_flush), .id_ex_bubble_o(bubble),
        .pipe_freeze_o(freeze), .mem_err_o(mem_err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: started/halted flags plus a count of consecutive wait cycles
    bit          m_started, m_halted, m_err;
    int          m_waits;
    logic [31:0] m_stall, m_flush;

    // Expected {pc_write, if_id_write, flush, bubble, freeze}
    function automatic logic [4:0] exp_out();
        logic hazard, waitm;
        if (!m_started || m_halted) return 5'b00011;
        hazard = memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        waitm  = req && !ack;
        if (waitm)  return 5'b00001;
        if (hazard) return 5'b00010;
        if (br)     return 5'b11100;
        return 5'b11000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_started <= 1'b0; m_halted <= 1'b0; m_err <= 1'b0;
            m_waits <= 0; m_stall <= 32'd0; m_flush <= 32'd0;
        end else if (!m_started) begin
            m_started <= start;
        end else if (!m_halted) begin
            if (!exp_out()[4]) m_stall <= m_stall + 32'd1;
            if (exp_out()[2])  m_flush <= m_flush + 32'd1;
            if (req && !ack) begin
                m_waits <= m_waits + 1;
                if (m_waits + 1 == TP) begin
                    m_halted <= 1'b1;
                    m_err    <= 1'b1;
                end
            end else begin
                m_waits <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst) begin
            e = exp_out();
            chk("model_pc_write", {31'd0, pc_write}, {31'd0, e[4]});
            chk("model_if_id_write", {31'd0, if_id_write}, {31'd0, e[3]});
            chk("model_flush", {31'd0, if_id_flush}, {31'd0, e[2]});
            chk("model_bubble", {31'd0, bubble}, {31'd0, e[1]});
            chk("model_freeze", {31'd0, freeze}, {31'd0, e[0]});
            chk("model_mem_err", {31'd0, mem_err}, {31'd0, m_err});
`ifdef PIPE_PERF_CNT_EN
            chk("model_stall_cnt", stall_cnt, m_stall);
            chk("model_flush_cnt", flush_cnt, m_flush);
`else
            chk("model_stall_cnt", stall_cnt, 32'd0);
            chk("model_flush_cnt", flush_cnt, 32'd0);
`endif
        end
    end

    task automatic cyc(input logic s, input logic mr, input logic [4:0] d, input logic [4:0] a,
                       input logic [4:0] b, input logic bt, input logic rq, input logic ak);
        @(posedge clk);
        #1;
        start = s; memread = mr; rd = d; rs1 = a; rs2 = b; br = bt; req = rq; ack = ak;
        @(negedge clk);
    endtask

    task automatic nop();
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; memread = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
        rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        #2;
        chk("reset_pc_write", {31'd0, pc_write}, 32'd0);
        chk("reset_freeze", {31'd0, freeze}, 32'd1);
        chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Held in IDLE while start is low
        repeat (5) nop();
        chk("idle_pc_write", {31'd0, pc_write}, 32'd0);
        chk("idle_bubble", {31'd0, bubble}, 32'd1);
        chk("idle_freeze", {31'd0, freeze}, 32'd1);
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        nop();
        chk("run_pc_write", {31'd0, pc_write}, 32'd1);
        chk("run_if_id_write", {31'd0, if_id_write}, 32'd1);
        chk("run_freeze", {31'd0, freeze}, 32'd0);

        // Perf scenario: 2 load-use stalls, 3 wait cycles, 1 flush
        cyc(1'b0, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
        chk("lu_bubble", {31'd0, bubble}, 32'd1);
        nop();
        chk("lu_released", {31'd0, pc_write}, 32'd1);
        cyc(1'b0, 1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_rs2_if_id_write", {31'd0, if_id_write}, 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("wait_freeze", {31'd0, freeze}, 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("ack_freeze", {31'd0, freeze}, 32'd0);
        chk("ack_pc_write", {31'd0, pc_write}, 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("branch_flush", {31'd0, if_id_flush}, 32'd1);
        nop();
`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall_literal", stall_cnt, 32'd5);
        chk("perf_flush_literal", flush_cnt, 32'd1);
`else
        chk("perf_stall_literal", stall_cnt, 32'd0);
        chk("perf_flush_literal", flush_cnt, 32'd0);
`endif

        // x0 never stalls
        cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x0_no_stall", {31'd0, pc_write}, 32'd1);
        // Load-use beats branch, branch seen next cycle
        cyc(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("lu_br_flush", {31'd0, if_id_flush}, 32'd0);
        chk("lu_br_bubble", {31'd0, bubble}, 32'd1);
        cyc(1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("br_after_lu_flush", {31'd0, if_id_flush}, 32'd1);
        // Back-to-back loads, each stalls once
        cyc(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        nop();
        cyc(1'b0, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        nop();
        // Memory wait beats load-use; start ignored while running
        cyc(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw_over_lu_bubble", {31'd0, bubble}, 32'd0);
        // Withdrawn request clears the count
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("no_trap_after_withdraw", {31'd0, mem_err}, 32'd0);

        // Timeout: 4 wait cycles without ack traps
        repeat (4) cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("pre_trap_mem_err", {31'd0, mem_err}, 32'd0);
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("trap_mem_err", {31'd0, mem_err}, 32'd1);
        chk("trap_pc_write", {31'd0, pc_write}, 32'd0);
        chk("trap_freeze", {31'd0, freeze}, 32'd1);
        repeat (3) cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("halt_sticky", {31'd0, mem_err}, 32'd1);
        chk("halt_no_flush", {31'd0, if_id_flush}, 32'd0);

        // Reset mid-wait returns to IDLE asynchronously
        rst = 1'b1;
        #1;
        chk("rst_clears_err", {31'd0, mem_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midwait_rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("midwait_rst_bubble", {31'd0, bubble}, 32'd1);
        chk("midwait_rst_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) nop();
        chk("after_rst_idle", {31'd0, pc_write}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
